crc_check_rx: RTL and testbench

- Receive side of the CRC path in the SPI execution unit.
- Takes a serial codeword MSB-first from the SPI deserialiser: WCODE data bits followed by WPOLY-1 CRC bits.
- Divides the codeword bit-serially by the generator polynomial and presents the data, received CRC and a pass/fail verdict to the downstream consumer.
- The verdict and data are delivered over a valid/ready handshake.

---
 rtl/spi_crc_pkg.sv | 16 +
 rtl/crc_div_step.sv | 25 ++
 rtl/crc_check_rx.sv | 150 +++++++++++++++
 tb/tb_crc_check_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_crc_pkg.sv
// Shared types and helpers for the SPI CRC path (receiver and transmitter).
// Frame length is kept here so both ends agree on codeword size.
package spi_crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } crc_rx_state_t;

  // Codeword length: data bits followed by the CRC bits.
  function automatic int crc_len(input int wcode, input int wpoly);
    return wcode + wpoly - 1;
  endfunction

endpackage

// File: rtl/crc_div_step.sv
// One bit of GF(2) polynomial long division: shift the next codeword bit into
// the remainder and subtract (xor) the generator when the dropped MSB was set.
module crc_div_step #(
  parameter int WPOLY = 3
) (
  input  logic [WPOLY-2:0] rem,
  input  logic             din,
  input  logic [WPOLY-2:0] poly,
  output logic [WPOLY-2:0] rem_next
);

  logic [WPOLY-2:0] shifted;

  // A 1-bit CRC has nothing to shift; the remainder is just the incoming bit.
  generate
    if (WPOLY == 2) begin : g_one_bit
      assign shifted = din;
    end else begin : g_multi_bit
      assign shifted = {rem[WPOLY-3:0], din};
    end
  endgenerate

  assign rem_next = shifted ^ (rem[WPOLY-2] ? poly : '0);

endmodule

// File: rtl/crc_check_rx.sv
// Serial CRC checker: collects a codeword MSB-first, divides it by the generator
// latched at the first bit, and hands data, CRC and verdict over valid/ready.
module crc_check_rx
  import spi_crc_pkg::*;
#(
  parameter int WCODE = 4,
  parameter int WPOLY = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WPOLY-1:0] i_poly,
  input  logic             i_bit,
  input  logic             i_bit_vld,
  output logic             o_bit_rdy,
  output logic [WCODE-1:0] o_data,
  output logic [WPOLY-2:0] o_crc,
  output logic [WPOLY-2:0] o_syndrome,
  output logic             o_crc_ok,
  output logic             o_vld,
  input  logic             i_rdy
);

  localparam int LEN  = crc_len(WCODE, WPOLY);
  localparam int CW   = WPOLY - 1;
  localparam int CNTW = $clog2(LEN + 1);

  crc_rx_state_t   state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   poly_q, poly_d;
  logic [LEN-1:0]  sr_q, sr_d;
  logic [WCODE-1:0] data_q, data_d;
  logic [CW-1:0]   crc_q, crc_d;
  logic [CW-1:0]   syn_q, syn_d;
  logic            ok_q, ok_d;
  logic            vld_q, vld_d;

  logic            bit_acc;
  logic [CW-1:0]   step_rem_in;
  logic [CW-1:0]   step_poly_in;
  logic [CW-1:0]   step_rem_out;
  logic [LEN-1:0]  cw_next;

  // The x^(WPOLY-1) term of the generator is implied by the division.
  logic unused_poly_msb;
  assign unused_poly_msb = i_poly[WPOLY-1];

  assign o_bit_rdy = (state_q != DONE);
  assign bit_acc   = i_bit_vld && o_bit_rdy;
  assign cw_next   = {sr_q[LEN-2:0], i_bit};

  // A new frame starts from a zero remainder; poly is irrelevant then (fb = 0).
  assign step_rem_in  = (state_q == IDLE) ? '0 : rem_q;
  assign step_poly_in = (state_q == IDLE) ? i_poly[CW-1:0] : poly_q;

  crc_div_step #(
    .WPOLY(WPOLY)
  ) u_step (
    .rem     (step_rem_in),
    .din     (i_bit),
    .poly    (step_poly_in),
    .rem_next(step_rem_out)
  );

  always_comb begin
    // NOTE: every _d signal takes its held value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    poly_d  = poly_q;
    sr_d    = sr_q;
    data_d  = data_q;
    crc_d   = crc_q;
    syn_d   = syn_q;
    ok_d    = ok_q;
    vld_d   = vld_q;

    unique case (state_q)
      IDLE: begin
        if (bit_acc) begin
          poly_d  = i_poly[CW-1:0];
          rem_d   = step_rem_out;
          sr_d    = {{(LEN-1){1'b0}}, i_bit};
          cnt_d   = CNTW'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (bit_acc) begin
          rem_d = step_rem_out;
          sr_d  = cw_next;
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(LEN - 1)) begin
            state_d = DONE;
            vld_d   = 1'b1;
            data_d  = cw_next[LEN-1:CW];
            crc_d   = cw_next[CW-1:0];
            syn_d   = step_rem_out;
            ok_d    = (step_rem_out == '0);
          end
        end
      end
      DONE: begin
        // Result fields stay put after the handshake; only valid drops.
        if (i_rdy) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      poly_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      crc_q   <= '0;
      syn_q   <= '0;
      ok_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      poly_q  <= poly_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      syn_q   <= syn_d;
      ok_q    <= ok_d;
      vld_q   <= vld_d;
    end
  end

  assign o_data     = data_q;
  assign o_crc      = crc_q;
  assign o_syndrome = syn_q;
  assign o_crc_ok   = ok_q;
  assign o_vld      = vld_q;

endmodule

// File: tb/tb_crc_check_rx.sv
// Bench for crc_check_rx: fixed vector table, hand sequences for abort/reset/
// poly-change corners, and random frames checked against a long-division model.
module tb_crc_check_rx;

  localparam int WCODE = 4;
  localparam int WPOLY = 3;
  localparam int CW    = WPOLY - 1;
  localparam int LEN   = WCODE + WPOLY - 1;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_clr;
  logic [WPOLY-1:0] i_poly;
  logic             i_bit;
  logic             i_bit_vld;
  logic             o_bit_rdy;
  logic [WCODE-1:0] o_data;
  logic [CW-1:0]    o_crc;
  logic [CW-1:0]    o_syndrome;
  logic             o_crc_ok;
  logic             o_vld;
  logic             i_rdy;

  int checks = 0;
  int errors = 0;

  crc_check_rx #(
    .WCODE(WCODE),
    .WPOLY(WPOLY)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_clr),
    .i_poly    (i_poly),
    .i_bit     (i_bit),
    .i_bit_vld (i_bit_vld),
    .o_bit_rdy (o_bit_rdy),
    .o_data    (o_data),
    .o_crc     (o_crc),
    .o_syndrome(o_syndrome),
    .o_crc_ok  (o_crc_ok),
    .o_vld     (o_vld),
    .i_rdy     (i_rdy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [WPOLY-1:0] poly;
    logic [LEN-1:0]   cw;
    logic [WCODE-1:0] e_data;
    logic [CW-1:0]    e_crc;
    logic [CW-1:0]    e_syn;
    logic             e_ok;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Textbook GF(2) long division on the whole codeword, generator with its
  // implied leading one.
  function automatic logic [CW-1:0] ref_div(input logic [WPOLY-1:0] poly,
                                            input logic [LEN-1:0] cw);
    logic [LEN-1:0]   r;
    logic [WPOLY-1:0] g;
    r = cw;
    g = {1'b1, poly[CW-1:0]};
    for (int i = LEN - 1; i >= CW; i--)
      if (r[i]) r = r ^ (LEN'(g) << (i - CW));
    return r[CW-1:0];
  endfunction

  task automatic expect_result(input string name, input logic [WPOLY-1:0] poly,
                               input logic [LEN-1:0] cw);
    logic [CW-1:0] syn;
    syn = ref_div(poly, cw);
    check({name, ".data"}, 32'(o_data), 32'(cw[LEN-1:CW]));
    check({name, ".crc"},  32'(o_crc),  32'(cw[CW-1:0]));
    check({name, ".syn"},  32'(o_syndrome), 32'(syn));
    check({name, ".ok"},   32'(o_crc_ok), 32'(syn == '0));
  endtask

  // Starts and ends just after a falling edge; poly switches to poly2 before
  // bit number chg_at (0-based) is offered.
  task automatic drive_frame(input logic [WPOLY-1:0] poly, input logic [LEN-1:0] cw,
                             input int gap, input int chg_at, input logic [WPOLY-1:0] poly2);
    i_poly = poly;
    for (int i = LEN - 1; i >= 0; i--) begin
      int n;
      n = 0;
      if (LEN - 1 - i == chg_at) i_poly = poly2;
      i_bit     = cw[i];
      i_bit_vld = 1'b1;
      while (!o_bit_rdy && n < 20) begin
        @(negedge i_clk);
        n++;
      end
      if (n >= 20) check("bit_rdy_timeout", 32'(o_bit_rdy), 32'd1);
      @(negedge i_clk);
      i_bit_vld = 1'b0;
      if (i > 0) repeat (gap) @(negedge i_clk);
    end
    check("latency_vld", 32'(o_vld), 32'd1);
  endtask

  // Holds the result for 'wait_cycles', optionally offering a bit during DONE,
  // then completes the handshake.
  task automatic handshake(input string name, input int wait_cycles, input logic hold_bit,
                           input logic [WPOLY-1:0] poly, input logic [LEN-1:0] cw);
    i_bit     = 1'b1;
    i_bit_vld = hold_bit;
    for (int k = 0; k < wait_cycles; k++) begin
      @(negedge i_clk);
      check({name, ".wait_vld"}, 32'(o_vld), 32'd1);
      check({name, ".wait_bit_rdy"}, 32'(o_bit_rdy), 32'd0);
      expect_result({name, ".held"}, poly, cw);
    end
    i_rdy = 1'b1;
    @(negedge i_clk);
    i_rdy     = 1'b0;
    i_bit_vld = 1'b0;
    check({name, ".post_vld"}, 32'(o_vld), 32'd0);
    check({name, ".post_bit_rdy"}, 32'(o_bit_rdy), 32'd1);
  endtask

  task automatic check_zero_state(input string name);
    check({name, ".vld"},     32'(o_vld),      32'd0);
    check({name, ".bit_rdy"}, 32'(o_bit_rdy),  32'd1);
    check({name, ".data"},    32'(o_data),     32'd0);
    check({name, ".crc"},     32'(o_crc),      32'd0);
    check({name, ".syn"},     32'(o_syndrome), 32'd0);
    check({name, ".ok"},      32'(o_crc_ok),   32'd0);
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_clr     = 1'b0;
    i_poly    = '0;
    i_bit     = 1'b0;
    i_bit_vld = 1'b0;
    i_rdy     = 1'b0;

    // Hand-derived vectors: good frames, single-bit errors, ignored poly MSB.
    vecs[0] = '{3'b101, 6'b110110, 4'b1101, 2'b10, 2'b00, 1'b1};
    vecs[1] = '{3'b101, 6'b110111, 4'b1101, 2'b11, 2'b01, 1'b0};
    vecs[2] = '{3'b101, 6'b010110, 4'b0101, 2'b10, 2'b10, 1'b0};
    vecs[3] = '{3'b111, 6'b100011, 4'b1000, 2'b11, 2'b00, 1'b1};
    vecs[4] = '{3'b011, 6'b100011, 4'b1000, 2'b11, 2'b00, 1'b1};
    vecs[5] = '{3'b101, 6'b000000, 4'b0000, 2'b00, 2'b00, 1'b1};
    vecs[6] = '{3'b101, 6'b111111, 4'b1111, 2'b11, 2'b11, 1'b0};

    repeat (2) @(negedge i_clk);
    check_zero_state("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    foreach (vecs[v]) begin
      drive_frame(vecs[v].poly, vecs[v].cw, 0, -1, vecs[v].poly);
      check($sformatf("vec%0d.data", v), 32'(o_data),     32'(vecs[v].e_data));
      check($sformatf("vec%0d.crc", v),  32'(o_crc),      32'(vecs[v].e_crc));
      check($sformatf("vec%0d.syn", v),  32'(o_syndrome), 32'(vecs[v].e_syn));
      check($sformatf("vec%0d.ok", v),   32'(o_crc_ok),   32'(vecs[v].e_ok));
      handshake($sformatf("vec%0d", v), 0, 1'b0, vecs[v].poly, vecs[v].cw);
    end

    // Gapped input, consumer stalls 5 cycles while a bit is offered in DONE.
    drive_frame(3'b101, 6'b110110, 1, -1, 3'b101);
    expect_result("gap", 3'b101, 6'b110110);
    handshake("gap", 5, 1'b1, 3'b101, 6'b110110);
    drive_frame(3'b101, 6'b110110, 0, -1, 3'b101);
    expect_result("after_done_bit", 3'b101, 6'b110110);
    check("after_done_bit.ok", 32'(o_crc_ok), 32'd1);
    handshake("after_done_bit", 0, 1'b0, 3'b101, 6'b110110);

    // Abort after 3 bits, then a clean frame.
    i_poly    = 3'b111;
    i_bit_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_bit = 1'b1;
      @(negedge i_clk);
    end
    i_bit_vld = 1'b0;
    i_clr     = 1'b1;
    @(negedge i_clk);
    i_clr = 1'b0;
    check("clr_mid.vld", 32'(o_vld), 32'd0);
    check("clr_mid.bit_rdy", 32'(o_bit_rdy), 32'd1);
    drive_frame(3'b101, 6'b110110, 0, -1, 3'b101);
    expect_result("after_clr", 3'b101, 6'b110110);
    check("after_clr.ok", 32'(o_crc_ok), 32'd1);
    handshake("after_clr", 0, 1'b0, 3'b101, 6'b110110);

    // Abort discards a pending result.
    drive_frame(3'b101, 6'b110111, 0, -1, 3'b101);
    i_clr = 1'b1;
    @(negedge i_clk);
    i_clr = 1'b0;
    check_zero_state("clr_done");

    // Poly changes mid-frame must not matter.
    drive_frame(3'b101, 6'b110110, 0, 2, 3'b111);
    check("poly_chg_a.ok", 32'(o_crc_ok), 32'd1);
    handshake("poly_chg_a", 0, 1'b0, 3'b101, 6'b110110);
    drive_frame(3'b111, 6'b100011, 0, 2, 3'b101);
    check("poly_chg_b.ok", 32'(o_crc_ok), 32'd1);
    check("poly_chg_b.syn", 32'(o_syndrome), 32'd0);
    handshake("poly_chg_b", 0, 1'b0, 3'b111, 6'b100011);

    // Reset while a result is pending.
    drive_frame(3'b101, 6'b110110, 0, -1, 3'b101);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check_zero_state("rst_done");
    drive_frame(3'b101, 6'b010110, 0, -1, 3'b101);
    expect_result("after_rst", 3'b101, 6'b010110);
    handshake("after_rst", 0, 1'b0, 3'b101, 6'b010110);

    // Random frames, half carrying a correct CRC.
    for (int f = 0; f < 200; f++) begin
      logic [WPOLY-1:0] poly;
      logic [WCODE-1:0] data;
      logic [CW-1:0]    crc;
      logic [LEN-1:0]   cw;
      poly = WPOLY'($urandom_range(0, 7));
      data = WCODE'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) crc = ref_div(poly, {data, {CW{1'b0}}});
      else                           crc = CW'($urandom_range(0, 3));
      cw = {data, crc};
      drive_frame(poly, cw, $urandom_range(0, 2), -1, poly);
      expect_result($sformatf("rnd%0d", f), poly, cw);
      handshake($sformatf("rnd%0d", f), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                poly, cw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
